// File: rtl/arinc429_tx.sv
// ARINC-429 RZ bipolar line transmitter.
//
// Accepts 32-bit words over a valid/ready handshake into a one-word holding
// buffer and serialises each word MSB first as return-to-zero bipolar pulses
// on line_A ("one") and line_B ("zero"), followed by a null gap.
//
// Parameters:
//   HALF_BIT_CLKS  clock cycles per half-bit
//   GAP_BITS       null bit-times between words
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous, active-high
//   data_in     word to transmit
//   data_valid  data_in is valid
//   data_ready  holding buffer empty (accept on data_valid && data_ready)
//   line_A      RZ "one" line (registered)
//   line_B      RZ "zero" line (registered)
//   busy        shifter in BIT_HI, BIT_LO or GAP
//   word_done   one-clock pulse at the end of the low half of bit 0
//
// Build option:
//   ARINC429_TX_PARITY_EN  when defined, transmitted bit 31 is replaced by
//                          odd parity over bits 30:0 on every load.
module arinc429_tx #(
   parameter int unsigned HALF_BIT_CLKS = 2,
   parameter int unsigned GAP_BITS      = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] data_in,
   input  logic        data_valid,
   output logic        data_ready,
   output logic        line_A,
   output logic        line_B,
   output logic        busy,
   output logic        word_done
);

   localparam int unsigned GAP_CLKS = GAP_BITS * 2 * HALF_BIT_CLKS;
   localparam int unsigned HW       = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;
   localparam int unsigned GW       = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

   localparam logic [HW-1:0] HALF_LAST = HW'(HALF_BIT_CLKS - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CLKS - 1);

   typedef enum logic [1:0] {
      IDLE,
      BIT_HI,
      BIT_LO,
      GAP
   } state_t;

   state_t        state;
   logic [31:0]   hold;
   logic          hold_full;
   logic [31:0]   shift_reg;
   logic [4:0]    bit_cnt;
   logic [HW-1:0] half_cnt;
   logic [GW-1:0] gap_cnt;

   logic          accept;
   logic          load;

   // Image actually shifted out for a buffered word.
   function automatic logic [31:0] tx_image(input logic [31:0] w);
`ifdef ARINC429_TX_PARITY_EN
      return {~^w[30:0], w[30:0]};
`else
      return w;
`endif
   endfunction

   assign data_ready = !hold_full;
   assign busy       = (state != IDLE);

   always_comb begin
      accept = data_valid && !hold_full;
      load   = hold_full &&
               ((state == IDLE) || ((state == GAP) && (gap_cnt == GAP_LAST)));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         hold      <= '0;
         hold_full <= 1'b0;
         shift_reg <= '0;
         bit_cnt   <= '0;
         half_cnt  <= '0;
         gap_cnt   <= '0;
         line_A    <= 1'b0;
         line_B    <= 1'b0;
         word_done <= 1'b0;
      end else begin
         word_done <= 1'b0;

         // Lines are registered from the present state, so they trail the
         // state machine by one clock: load at t+1, first half-bit after t+2.
         // Both are gated by BIT_HI and split on one bit, so never both 1.
         line_A <= (state == BIT_HI) &&  shift_reg[31];
         line_B <= (state == BIT_HI) && !shift_reg[31];

         // Accept after load so a same-edge accept keeps the buffer full.
         if (load)
            hold_full <= 1'b0;
         if (accept) begin
            hold      <= data_in;
            hold_full <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (load) begin
                  shift_reg <= tx_image(hold);
                  bit_cnt   <= 5'd31;
                  half_cnt  <= '0;
                  state     <= BIT_HI;
               end
            end

            BIT_HI: begin
               if (half_cnt == HALF_LAST) begin
                  half_cnt <= '0;
                  state    <= BIT_LO;
               end else begin
                  half_cnt <= half_cnt + 1'b1;
               end
            end

            BIT_LO: begin
               if (half_cnt == HALF_LAST) begin
                  half_cnt <= '0;
                  if (bit_cnt == 5'd0) begin
                     word_done <= 1'b1;
                     gap_cnt   <= '0;
                     state     <= GAP;
                  end else begin
                     shift_reg <= {shift_reg[30:0], 1'b0};
                     bit_cnt   <= bit_cnt - 1'b1;
                     state     <= BIT_HI;
                  end
               end else begin
                  half_cnt <= half_cnt + 1'b1;
               end
            end

            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  gap_cnt <= '0;
                  if (load) begin
                     // Chain straight into the next word without an IDLE cycle.
                     shift_reg <= tx_image(hold);
                     bit_cnt   <= 5'd31;
                     half_cnt  <= '0;
                     state     <= BIT_HI;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_arinc429_tx.sv
// Testbench for arinc429_tx: randomized and directed bursts compared cycle by
// cycle against a timing model derived from the word/bit/gap arithmetic, plus
// a loopback receiver that rebuilds words from the line pulses.
module tb_arinc429_tx;

   localparam int H  = 2;
   localparam int G  = 4;
   localparam int WT = 64 * H;            // word time in clocks
   localparam int P  = (64 + 2 * G) * H;  // back-to-back period
   localparam int MAXREC = 512;

   logic        clock;
   logic        reset;
   logic [31:0] data_in;
   logic        data_valid;
   logic        data_ready;
   logic        line_A;
   logic        line_B;
   logic        busy;
   logic        word_done;

   int checks   = 0;
   int failures = 0;

   logic [31:0] wq [0:3];
   logic [31:0] tw [0:3];
   logic [4:0]  rec [0:MAXREC-1];

   // loopback receiver state
   logic        mon_en;
   logic        rx_prev;
   logic [31:0] rx_sh;
   int          rx_bits;
   int          rx_addr;
   logic [31:0] rx_mem [0:7];
   int          overlap = 0;

   arinc429_tx #(.HALF_BIT_CLKS(H), .GAP_BITS(G)) dut (
      .clock      (clock),
      .reset      (reset),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .line_A     (line_A),
      .line_B     (line_B),
      .busy       (busy),
      .word_done  (word_done)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   always @(negedge clock)
      if (line_A && line_B)
         overlap <= overlap + 1;

   // Receiver: left-shift line_A on each rising edge of (line_A | line_B).
   always @(negedge clock) begin
      if (!mon_en) begin
         rx_prev <= 1'b0;
         rx_bits <= 0;
         rx_addr <= 0;
         rx_sh   <= '0;
      end else begin
         if ((line_A || line_B) && !rx_prev) begin
            if (rx_bits == 31) begin
               if (rx_addr < 8)
                  rx_mem[rx_addr] <= {rx_sh[30:0], line_A};
               rx_addr <= rx_addr + 1;
               rx_bits <= 0;
            end else begin
               rx_sh   <= {rx_sh[30:0], line_A};
               rx_bits <= rx_bits + 1;
            end
         end
         rx_prev <= line_A || line_B;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] tx_word(input logic [31:0] w);
`ifdef ARINC429_TX_PARITY_EN
      return {~^w[30:0], w[30:0]};
`else
      return w;
`endif
   endfunction

   // Expected {line_A, line_B, busy, word_done, data_ready} at sample i,
   // i = clocks after the first word's accept edge, for nw words pushed ASAP.
   function automatic logic [4:0] exp_sig(input int i, input int nw);
      logic a, b, bz, wd, rdy;
      int   k, j, bi;
      a  = 1'b0;
      b  = 1'b0;
      bz = (i >= 1) && (i <= nw * P);
      wd = 1'b0;
      for (int q = 0; q < nw; q++)
         if (i == 1 + q * P + WT) wd = 1'b1;
      if (i >= 2) begin
         k = (i - 2) / P;
         j = (i - 2) % P;
         if (k < nw && j < WT) begin
            bi = 31 - j / (2 * H);
            if ((j % (2 * H)) < H) begin
               a = tw[k][bi];
               b = !tw[k][bi];
            end
         end
      end
      rdy = (i != 0);
      for (int q = 1; q < nw; q++)
         if (i >= 2 + (q - 1) * P && i <= q * P) rdy = 1'b0;
      return {a, b, bz, wd, rdy};
   endfunction

   task automatic clear_monitor();
      @(posedge clock); #1 mon_en = 1'b0;
      @(posedge clock); #1 mon_en = 1'b1;
   endtask

   // Wait (bounded) for data_ready at a falling edge, then accept one word.
   task automatic push_word(input logic [31:0] w, input string tag);
      int waited;
      waited = 0;
      @(negedge clock);
      while (!data_ready && waited < 4 * P) begin
         @(negedge clock);
         waited++;
      end
      if (!data_ready)
         check({tag, "_ready_timeout"}, 32'(data_ready), 32'd1);
      data_in    = w;
      data_valid = 1'b1;
      @(posedge clock);
      #1 data_valid = 1'b0;
   endtask

   task automatic run_burst(input int nw);
      int n;
      n = nw * P + 10;
      for (int k = 0; k < nw; k++)
         tw[k] = tx_word(wq[k]);
      clear_monitor();
      push_word(wq[0], "w0");
      fork
         begin
            for (int k = 1; k < nw; k++)
               push_word(wq[k], "wn");
         end
         begin
            for (int i = 0; i < n; i++) begin
               @(negedge clock);
               rec[i] = {line_A, line_B, busy, word_done, data_ready};
            end
         end
      join
      for (int i = 0; i < n; i++)
         check($sformatf("wave@%0d", i), 32'(rec[i]), 32'(exp_sig(i, nw)));
      check("rx_count", 32'(rx_addr), 32'(nw));
      for (int k = 0; k < nw; k++)
         check($sformatf("rx_word%0d", k), rx_mem[k], tw[k]);
   endtask

   task automatic reset_mid_word();
      int pulses, dones;
      push_word($urandom(), "r0");
      @(negedge clock);              // sample 0
      @(negedge clock);              // sample 1
      data_in    = $urandom();
      data_valid = 1'b1;
      @(posedge clock);
      #1 data_valid = 1'b0;
      repeat (85) @(negedge clock); // sample 86: bit 10 high half
      check("rst_mid_hi", 32'(line_A | line_B), 32'd1);
      check("rst_mid_full", 32'(data_ready), 32'd0);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("rst_mid_lineA", 32'(line_A), 32'd0);
      check("rst_mid_lineB", 32'(line_B), 32'd0);
      check("rst_mid_ready", 32'(data_ready), 32'd1);
      check("rst_mid_busy", 32'(busy), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      pulses = 0;
      dones  = 0;
      repeat (2 * P) begin
         @(negedge clock);
         if (line_A || line_B) pulses++;
         if (word_done) dones++;
      end
      check("rst_no_pulse", 32'(pulses), 32'd0);
      check("rst_no_done", 32'(dones), 32'd0);
      check("rst_after_ready", 32'(data_ready), 32'd1);
   endtask

   initial begin
      int busy_cnt;
      logic exp_b31;
      reset      = 1'b1;
      data_in    = '0;
      data_valid = 1'b0;
      mon_en     = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_lineA", 32'(line_A), 32'd0);
      check("rst_lineB", 32'(line_B), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(word_done), 32'd0);
      check("rst_ready", 32'(data_ready), 32'd1);
      reset = 1'b0;

      // single word 0x8000_0001
      wq[0] = 32'h8000_0001;
      run_burst(1);
      busy_cnt = 0;
      for (int i = 0; i < P + 10; i++)
         if (rec[i][2]) busy_cnt++;
      check("busy_len", 32'(busy_cnt), 32'(WT + 2 * G * H));
      check("done_at_word_end", 32'(rec[1 + WT][1]), 32'd1);

      // bit 31 under optional parity
      wq[0] = 32'h0000_0000;
      run_burst(1);
`ifdef ARINC429_TX_PARITY_EN
      exp_b31 = 1'b1;
`else
      exp_b31 = 1'b0;
`endif
      check("b31_word0", 32'(rec[2][4]), 32'(exp_b31));
      wq[0] = 32'h0000_0001;
      run_burst(1);
      check("b31_word1", 32'(rec[2][4]), 32'd0);

      // back-to-back pair with loopback
      wq[0] = 32'hA5A5_5A5A;
      wq[1] = 32'h0F0F_F0F0;
      run_burst(2);
      check("b2b_ready_drop", 32'(rec[2][0]), 32'd0);
      check("b2b_no_idle", 32'(rec[P + 1][2]), 32'd1);
      check("b2b_second_start", 32'(rec[2 + P][4] | rec[2 + P][3]), 32'd1);

      reset_mid_word();

      // randomized bursts
      for (int r = 0; r < 6; r++) begin
         int nw;
         nw = $urandom_range(1, 3);
         for (int k = 0; k < nw; k++)
            wq[k] = $urandom();
         run_burst(nw);
      end

      check("no_overlap", 32'(overlap), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
